// File: rtl/rr_mem_arbiter_pkg.sv
// Shared types and constants for the round-robin RAM arbiter.
// State encodings match the legacy ARB_IDLE/ARB_ACCESS/ARB_RDATA values.
package rr_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RDATA  = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_STAT_W = 16;

  function automatic logic [ARB_STAT_W-1:0] sat_inc(input logic [ARB_STAT_W-1:0] v);
    return (v == '1) ? v : v + ARB_STAT_W'(1);
  endfunction

endpackage

// File: rtl/rr_mem_arbiter_if.sv
// Requester and RAM-side bus of rr_mem_arbiter.
// slave = arbiter view, master = cores/RAM view.
interface rr_mem_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wr;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_din;
  logic               ram_wren;
  logic [DW-1:0]      ram_q;
  logic               busy;

  modport slave (
    input  req, wr, addr, wdata, ram_q,
    output gnt, rvalid, rdata, ram_addr, ram_din, ram_wren, busy
  );

  modport master (
    output req, wr, addr, wdata, ram_q,
    input  gnt, rvalid, rdata, ram_addr, ram_din, ram_wren, busy
  );
endinterface

// File: rtl/rr_mem_arbiter_pick.sv
// Combinational round-robin picker: first unmasked request at or after rr_ptr.
module rr_priority_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   rr_ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);
  logic [NREQ-1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin : pick
    logic [PW-1:0] j;
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = PW'((32'(rr_ptr) + k) % NREQ);
      if (!found && eligible[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NREQ cores.
// Define ARB_STATS_EN to add saturating grant/conflict counters (stat_* ports).
module rr_mem_arbiter
  import rr_mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8
) (
  input  logic clk,
  input  logic rst,
  rr_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NREQ*ARB_STAT_W-1:0] stat_grants,
  output logic [ARB_STAT_W-1:0]      stat_conflicts
`endif
);
  localparam int unsigned   PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_din_q, ram_din_d;
  logic            ram_wren_q, ram_wren_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q;

  logic            arb_en, found, take;
  logic [NREQ-1:0] mask, owner_oh;
  logic [PW-1:0]   idx;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      owner_oh[i] = (owner_q == PW'(i));
    end
  end

  // A read in ACCESS does not arbitrate; a write masks its owner for one round.
  always_comb begin
    arb_en = 1'b0;
    mask   = '0;
    case (state_q)
      ARB_IDLE:   arb_en = 1'b1;
      ARB_ACCESS: begin
        arb_en = wr_q;
        mask   = owner_oh;
      end
      ARB_RDATA:  arb_en = 1'b1;
      default:    arb_en = 1'b0;
    endcase
  end

  rr_priority_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (bus.req),
    .mask   (mask),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .idx    (idx)
  );

  assign take = arb_en & found;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (idx == PW'(i)) begin
        sel_wr    = bus.wr[i];
        sel_addr  = bus.addr[i*AW +: AW];
        sel_wdata = bus.wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   state_d = take ? ARB_ACCESS : ARB_IDLE;
      ARB_ACCESS: begin
        if (!wr_q)     state_d = ARB_RDATA;
        else if (take) state_d = ARB_ACCESS;
        else           state_d = ARB_IDLE;
      end
      ARB_RDATA:  state_d = take ? ARB_ACCESS : ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    wr_d       = wr_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wren_d = 1'b0;
    gnt_d      = '0;
    rvalid_d   = '0;
    if (take) begin
      owner_d    = idx;
      rr_ptr_d   = (idx == LAST) ? '0 : idx + PW'(1);
      wr_d       = sel_wr;
      ram_addr_d = sel_addr;
      ram_din_d  = sel_wdata;
      ram_wren_d = sel_wr;
      gnt_d      = owner_oh & '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        gnt_d[i] = (idx == PW'(i));
      end
    end
    if (state_q == ARB_ACCESS && !wr_q) begin
      rvalid_d = owner_oh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      wr_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_wren_q <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_q       <= wr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_wren_q <= ram_wren_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      if (state_q == ARB_RDATA) rdata_q <= bus.ram_q;
    end
  end

  // RAM q is itself a register, so RDATA forwards it in-cycle; rdata_q holds it afterwards.
  assign bus.rdata    = (state_q == ARB_RDATA) ? bus.ram_q : rdata_q;
  assign bus.gnt      = gnt_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_wren = ram_wren_q;
  assign bus.busy     = (state_q != ARB_IDLE);

`ifdef ARB_STATS_EN
  logic [ARB_STAT_W-1:0] grant_cnt_q [NREQ];
  logic [ARB_STAT_W-1:0] conflict_cnt_q;
  logic                  conflict;

  assign conflict = arb_en && ($countones(bus.req & ~mask) >= 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt_q[i]) grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
      end
      if (conflict) conflict_cnt_q <= sat_inc(conflict_cnt_q);
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_grants[i*ARB_STAT_W +: ARB_STAT_W] = grant_cnt_q[i];
    end
  end

  assign stat_conflicts = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed self-checking bench for rr_mem_arbiter (NREQ=3, AW=DW=8) with a 1-cycle RAM model.
module tb_rr_mem_arbiter;
  logic clk = 1'b0;
  logic rst;

  rr_mem_arbiter_if #(.NREQ(3), .AW(8), .DW(8)) bus ();

`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [47:0] stat_grants;
  logic [15:0] stat_conflicts;
`endif

  rr_mem_arbiter #(
    .NREQ (3),
    .AW   (8),
    .DW   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave)
`ifdef ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256] = '{default: 8'h00};
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;

  always @(posedge clk) begin
    if (bd_we)             mem[bd_addr] <= bd_data;
    else if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_q <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    bus.req[i]         = r;
    bus.wr[i]          = w;
    bus.addr[i*8 +: 8] = a;
    bus.wdata[i*8 +: 8] = d;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    bd_we     = 1'b0;
    bd_addr   = '0;
    bd_data   = '0;
    bus.req   = '0;
    bus.wr    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    tick();
    tick();
    check("rst_gnt",      32'(bus.gnt),      32'h0);
    check("rst_rvalid",   32'(bus.rvalid),   32'h0);
    check("rst_rdata",    32'(bus.rdata),    32'h0);
    check("rst_ram_wren", 32'(bus.ram_wren), 32'h0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rst_ram_din",  32'(bus.ram_din),  32'h0);
    check("rst_busy",     32'(bus.busy),     32'h0);
    rst = 1'b0;

    // all requests low: stay idle
    tick();
    tick();
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("idle_gnt",  32'(bus.gnt),  32'h0);
    check("idle_wren", 32'(bus.ram_wren), 32'h0);

    // 1. single write
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    tick();
    check("w1_gnt",  32'(bus.gnt),      32'h1);
    check("w1_wren", 32'(bus.ram_wren), 32'h1);
    check("w1_addr", 32'(bus.ram_addr), 32'h10);
    check("w1_din",  32'(bus.ram_din),  32'hA5);
    check("w1_busy", 32'(bus.busy),     32'h1);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("w1_busy_done", 32'(bus.busy), 32'h0);
    check("w1_gnt_done",  32'(bus.gnt),  32'h0);
    check("w1_mem",       32'(mem[8'h10]), 32'hA5);

    // 2. single read
    preload(8'h20, 8'h3C);
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    check("r2_gnt",  32'(bus.gnt),      32'h2);
    check("r2_wren", 32'(bus.ram_wren), 32'h0);
    check("r2_addr", 32'(bus.ram_addr), 32'h20);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("r2_rvalid", 32'(bus.rvalid), 32'h2);
    check("r2_rdata",  32'(bus.rdata),  32'h3C);
    check("r2_gnt_off", 32'(bus.gnt),   32'h0);
    tick();
    check("r2_rvalid_off", 32'(bus.rvalid), 32'h0);
    check("r2_busy_off",   32'(bus.busy),   32'h0);

    // 3. contention, rotation restarted from 0
    do_reset();
    set_req(0, 1'b1, 1'b1, 8'h30, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'h31, 8'h22);
    set_req(2, 1'b1, 1'b1, 8'h32, 8'h33);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rot_gnt%0d", k), 32'(bus.gnt), 32'(1 << (k % 3)));
    end
    bus.req = '0;
    tick();
    check("rot_busy_off", 32'(bus.busy), 32'h0);
    check("rot_mem0", 32'(mem[8'h30]), 32'h11);
    check("rot_mem1", 32'(mem[8'h31]), 32'h22);
    check("rot_mem2", 32'(mem[8'h32]), 32'h33);
`ifdef ARB_STATS_EN
    check("st_g0",   32'(stat_grants[15:0]),  32'd2);
    check("st_g1",   32'(stat_grants[31:16]), 32'd2);
    check("st_g2",   32'(stat_grants[47:32]), 32'd2);
    check("st_conf", 32'(stat_conflicts),     32'd6);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("st_clr_g",    32'(stat_grants == 48'h0), 32'h1);
    check("st_clr_conf", 32'(stat_conflicts),       32'h0);
`endif

    // 4. mixed read then write; rr_ptr wrapped to 0
    preload(8'h01, 8'h5A);
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(2, 1'b1, 1'b1, 8'h02, 8'h77);
    tick();
    check("mx_gnt0", 32'(bus.gnt), 32'h1);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("mx_rvalid0", 32'(bus.rvalid), 32'h1);
    check("mx_rdata0",  32'(bus.rdata),  32'h5A);
    check("mx_gnt_gap", 32'(bus.gnt),    32'h0);
    tick();
    check("mx_gnt2", 32'(bus.gnt),      32'h4);
    check("mx_wren", 32'(bus.ram_wren), 32'h1);
    check("mx_din",  32'(bus.ram_din),  32'h77);
    set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("mx_mem",  32'(mem[8'h02]), 32'h77);
    check("mx_busy", 32'(bus.busy),   32'h0);

    // 5a. reset during ACCESS of a read: no rvalid follows
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    check("ra_gnt", 32'(bus.gnt), 32'h2);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    check("ra_gnt_clr", 32'(bus.gnt),  32'h0);
    check("ra_busy",    32'(bus.busy), 32'h0);
    tick();
    check("ra_no_rvalid", 32'(bus.rvalid), 32'h0);
    check("ra_rdata",     32'(bus.rdata),  32'h0);
    rst = 1'b0;

    // 5b. reset during RDATA
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    check("rd_gnt", 32'(bus.gnt), 32'h2);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("rd_rvalid_pre", 32'(bus.rvalid), 32'h2);
    rst = 1'b1;
    #1;
    check("rd_rvalid_clr", 32'(bus.rvalid), 32'h0);
    check("rd_rdata_clr",  32'(bus.rdata),  32'h0);
    check("rd_busy_clr",   32'(bus.busy),   32'h0);
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h40, 8'h99);
    set_req(1, 1'b1, 1'b1, 8'h41, 8'h98);
    tick();
    check("rd_first_gnt", 32'(bus.gnt), 32'h1);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("rd_second_gnt", 32'(bus.gnt), 32'h2);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("rd_mem40", 32'(mem[8'h40]), 32'h99);
    check("rd_mem41", 32'(mem[8'h41]), 32'h98);

    // 5c. reset before the write edge: write not issued
    set_req(2, 1'b1, 1'b1, 8'h50, 8'hEE);
    tick();
    check("wa_gnt",  32'(bus.gnt),      32'h4);
    check("wa_wren", 32'(bus.ram_wren), 32'h1);
    set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    check("wa_wren_clr", 32'(bus.ram_wren), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("wa_mem", 32'(mem[8'h50]), 32'h00);

    // single requester re-requesting after writes: every second cycle
    set_req(0, 1'b1, 1'b1, 8'h60, 8'h01);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("mask_gnt%0d", k), 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("mask_mem", 32'(mem[8'h60]), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
